// File: rtl/wb_control_pipe.sv
// Control-signal pipeline from decode to writeback: decodes the opcode into
// mem_to_reg/reg_write/illegal and carries them through STAGES registers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, opcode,   instruction in decode
//   in_rd, rs, rt
//   stall, flush        freeze / kill all stages (flush wins)
//   out_valid, mem_to_reg, reg_write, illegal, out_rd   final-stage controls
//   load_use            load in stage 0 feeds a source of the decode instruction
//   illegal_cnt         saturating count of retired illegal opcodes
module wb_control_pipe #(
  parameter int STAGES        = 2,
  parameter int REG_W         = 5,
  parameter bit ZERO_SUPPRESS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       opcode,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [REG_W-1:0] out_rd,
  output logic             load_use,
  output logic [7:0]       illegal_cnt
);

  typedef struct packed {
    logic             v;
    logic             m2r;
    logic             rw;
    logic             ill;
    logic [REG_W-1:0] rd;
  } stage_t;

  stage_t     st_q [STAGES];
  stage_t     st_d [STAGES];
  stage_t     dec;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    dec     = '0;
    dec.v   = in_valid;
    dec.rd  = in_rd;
    case (opcode)
      6'b000000,
      6'b001000,
      6'b001101,
      6'b001100,
      6'b001010: dec.rw = 1'b1;
      6'b100011: begin
        dec.m2r = 1'b1;
        dec.rw  = 1'b1;
      end
      6'b101011,
      6'b000010,
      6'b000100,
      6'b000101: ;
      default:   dec.ill = 1'b1;
    endcase
    if (ZERO_SUPPRESS && in_rd == '0)
      dec.rw = 1'b0;
  end

  // Bubbles only clear the valid bit; the payload fields keep their last
  // contents so out_rd holds its value while out_valid is low.
  always_comb begin
    for (int k = 0; k < STAGES; k++)
      st_d[k] = st_q[k];
    if (flush) begin
      for (int k = 0; k < STAGES; k++)
        st_d[k].v = 1'b0;
    end else if (!stall) begin
      if (dec.v) st_d[0] = dec;
      else       st_d[0].v = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
        if (st_q[k-1].v) st_d[k] = st_q[k-1];
        else             st_d[k].v = 1'b0;
      end
    end
  end

  // An entry is counted only on the edge it leaves the output stage, so a
  // stalled illegal entry is counted once.
  always_comb begin
    cnt_d = cnt_q;
    if (st_q[STAGES-1].v && st_q[STAGES-1].ill && !stall && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++)
        st_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        st_q[k] <= st_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = st_q[STAGES-1].v;
  assign mem_to_reg  = st_q[STAGES-1].v & st_q[STAGES-1].m2r;
  assign reg_write   = st_q[STAGES-1].v & st_q[STAGES-1].rw;
  assign illegal     = st_q[STAGES-1].v & st_q[STAGES-1].ill;
  assign out_rd      = st_q[STAGES-1].rd;
  assign illegal_cnt = cnt_q;

  assign load_use = in_valid && !flush
                 && st_q[0].v && st_q[0].m2r && st_q[0].rw
                 && (st_q[0].rd == rs || st_q[0].rd == rt);

endmodule

// File: tb/tb_wb_control_pipe.sv
// Directed bench for wb_control_pipe (STAGES=2, REG_W=5, ZERO_SUPPRESS=1).
// Drives inputs 1 time unit after each rising edge and checks outputs there.
module tb_wb_control_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] opcode;
  logic [4:0] in_rd, rs, rt;
  logic       stall, flush;
  logic       out_valid, mem_to_reg, reg_write, illegal, load_use;
  logic [4:0] out_rd;
  logic [7:0] illegal_cnt;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  always #5 clk = ~clk;

  wb_control_pipe #(.STAGES(2), .REG_W(5), .ZERO_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
    .in_rd(in_rd), .rs(rs), .rt(rt), .stall(stall), .flush(flush),
    .out_valid(out_valid), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .out_rd(out_rd),
    .load_use(load_use), .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op,
                     input logic [4:0] d, input logic [4:0] s,
                     input logic [4:0] t);
    in_valid = v; opcode = op; in_rd = d; rs = s; rt = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic m,
                         input logic w, input logic il,
                         input logic [4:0] d);
    chk({tag, ".v"},  32'(out_valid),  32'(v));
    chk({tag, ".m2r"}, 32'(mem_to_reg), 32'(m));
    chk({tag, ".rw"}, 32'(reg_write),  32'(w));
    chk({tag, ".ill"}, 32'(illegal),   32'(il));
    chk({tag, ".rd"}, 32'(out_rd),     32'(d));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("reset.cnt", 32'(illegal_cnt), 0);
    chk("reset.lu", 32'(load_use), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic latency: lw rd=3
    drv(1'b1, OP_LW, 5'd3, 5'd0, 5'd0);
    step();
    chk("lat.e1.v", 32'(out_valid), 0);
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk_out("lat.e2", 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    step();
    chk_out("lat.bub", 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);

    // zero-register suppression
    drv(1'b1, OP_ADDI, 5'd0, 5'd0, 5'd0);
    step();
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk_out("zero", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

    // load-use detection
    drv(1'b1, OP_LW, 5'd5, 5'd0, 5'd0);
    step();
    drv(1'b1, OP_R, 5'd7, 5'd5, 5'd0);
    #1 chk("lu.rs", 32'(load_use), 1);
    rs = 5'd4; rt = 5'd6;
    #1 chk("lu.none", 32'(load_use), 0);
    rt = 5'd5;
    #1 chk("lu.rt", 32'(load_use), 1);
    in_valid = 1'b0;
    #1 chk("lu.noval", 32'(load_use), 0);
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("lu.flush", 32'(load_use), 0);
    flush = 1'b0; rt = 5'd6;
    step();
    chk_out("lu.out", 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);

    // stall holds the output and the counter
    drv(1'b1, OP_BAD, 5'd9, 5'd0, 5'd0);
    step();
    chk_out("r7", 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk_out("ill", 1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
    chk("ill.cnt0", 32'(illegal_cnt), 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
      chk("stall.cnt", 32'(illegal_cnt), 0);
    end
    stall = 1'b0;
    step();
    chk("ret.cnt", 32'(illegal_cnt), 1);
    chk_out("ret.hold", 1'b0, 1'b0, 1'b0, 1'b0, 5'd9);

    // flush together with stall
    drv(1'b1, OP_LW, 5'd2, 5'd0, 5'd0);
    step();
    drv(1'b1, OP_ORI, 5'd4, 5'd0, 5'd0);
    step();
    chk_out("pre.fl", 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush.v", 32'(out_valid), 0);
    chk("flush.rw", 32'(reg_write), 0);
    stall = 1'b0; flush = 1'b0;
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk("flush.killed", 32'(out_valid), 0);
    chk("flush.cnt", 32'(illegal_cnt), 1);

    // saturation: 300 illegal opcodes
    drv(1'b1, OP_BAD, 5'd1, 5'd0, 5'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) chk("sat.mid", 32'(illegal_cnt), 99);
    end
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) step();
    chk("sat.cnt", 32'(illegal_cnt), 255);

    // reset mid-stream with two entries in flight
    drv(1'b1, OP_LW, 5'd3, 5'd0, 5'd0);
    step();
    drv(1'b1, OP_ORI, 5'd4, 5'd0, 5'd0);
    step();
    chk_out("pre.rst", 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    #1 rst = 1'b1;
    #1;
    chk_out("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("rst.cnt", 32'(illegal_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk("rst.stale1", 32'(out_valid), 0);
    step();
    chk("rst.stale2", 32'(out_valid), 0);
    drv(1'b1, OP_ANDI, 5'd6, 5'd0, 5'd0);
    step();
    drv(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step();
    chk_out("resume", 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_control_pipe.md
WB_CONTROL_PIPE -- requirements
Module: wb_control_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, meaning the number of pipeline stages from decode to writeback outputs (legal 1..4).
REQ-002 SHALL have parameter REG_W, default 5, meaning the register-index width.
REQ-003 SHALL have parameter ZERO_SUPPRESS, default 1, meaning writes to register 0 are suppressed when set.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning opcode/in_rd carry a real instruction.
REQ-008 SHALL have port opcode, input, 6, instruction opcode.
REQ-009 SHALL have port in_rd, input, REG_W, destination register.
REQ-010 SHALL have ports rs and rt, input, REG_W each, source registers of the instruction in decode.
REQ-011 SHALL have port stall, input, 1, freeze all stages.
REQ-012 SHALL have port flush, input, 1, kill all in-flight entries.
REQ-013 SHALL have ports out_valid, mem_to_reg, reg_write, illegal, output, 1 each, final-stage controls.
REQ-014 SHALL have port out_rd, output, REG_W, final-stage destination.
REQ-015 SHALL have port load_use, output, 1, load-use hazard indication.
REQ-016 SHALL have port illegal_cnt, output, 8, saturating count of illegal opcodes retired.

Function
REQ-017 SHALL decode mem_to_reg/reg_write/illegal as follows: 000000 R-type, 001000 addi, 001101 ori, 001100 andi and 001010 slti give 0/1/0.
REQ-018 SHALL decode 100011 (lw) as mem_to_reg/reg_write/illegal 1/1/0.
REQ-019 SHALL decode 101011 sw, 000010 j, 000100 beq and 000101 bne as 0/0/0.
REQ-020 SHALL decode any other opcode as 0/0/1.
REQ-021 SHALL clear the decoded reg_write when ZERO_SUPPRESS=1 and in_rd=0.
REQ-022 SHALL hold a valid bit plus {mem_to_reg, reg_write, illegal, rd} in each stage.
REQ-023 SHALL load stage 0 from decode on each clock with stall=0, and shift each stage k into k+1.
REQ-024 SHALL load stage 0 with an invalid bubble when in_valid=0.
REQ-025 SHALL have fixed latency: an instruction accepted at edge N appears on the outputs after edge N+STAGES-1.
REQ-026 SHALL hold every stage unchanged, including valid bits, while stall=1.
REQ-027 SHALL clear all valid bits at the next edge when flush=1, taking priority over stall and in_valid.
REQ-028 SHALL drive mem_to_reg, reg_write and illegal as 0 whenever out_valid=0, with out_rd holding its last value.
REQ-029 SHALL assert load_use combinationally when stage 0 is valid with mem_to_reg=1, reg_write=1 and rd equal to rs or rt.
REQ-030 SHALL assert load_use only when in_valid=1 and flush=0.
REQ-031 SHALL increment illegal_cnt by 1 on each edge where out_valid=1, illegal=1 and stall=0, saturating at 255 with no wrap.
REQ-032 SHALL NOT count an entry held at the output for multiple stalled cycles more than once.

Reset
REQ-033 SHALL, while rst=1, asynchronously clear all valid bits, all stage fields, illegal_cnt and every output to 0.
REQ-034 SHALL discard any in-flight entry when reset asserts mid-operation, and SHALL resume acceptance on the first edge after rst deasserts.

Verification
REQ-035 SHALL verify basic latency (STAGES=2): lw rd=3 valid at edge 1 -> at edge 2 out_valid=1, mem_to_reg=1, reg_write=1, out_rd=3.
REQ-036 SHALL verify zero-register suppression: addi rd=0 -> reg_write=0 at output, out_valid=1.
REQ-037 SHALL verify load-use detection: lw rd=5 in stage 0 with rs=5 in decode -> load_use=1; the same with rs=4 and rt=6 -> load_use=0.
REQ-038 SHALL verify stall and flush: stall for 3 cycles -> outputs frozen and illegal_cnt unchanged; flush together with stall -> out_valid=0 next cycle.
REQ-039 SHALL verify counter saturation: 300 illegal opcodes (e.g. 111111) retired -> illegal_cnt=255.
REQ-040 SHALL verify reset mid-stream: rst pulsed with 2 entries in flight -> all outputs 0 immediately, and no stale entry emerges afterwards.
